controle_contador: RTL
======================

# controle_contador

Sequencing controller for the 7-bit shift/ring register (`contador`). It accepts one command at a time over a valid/ready handshake and drives the register's mode pair `ch1`/`ch0`, its parallel-load bits and its serial input `d` cycle by cycle. Supported operations are parallel load, shift-in of N serial bits, rotate by N steps and clear. It sits between the front-end control logic and the register, and reports completion with a one-cycle `done` pulse.

## Interface
- No parameters. Register width is fixed at 7, step count at 3 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept a command (IDLE only).
- `cmd_op` input 2: operation code.
  - 00: CLEAR.
  - 01: LOAD.
  - 10: SHIFT.
  - 11: ROTATE.
- `cmd_data` input 7: pattern for LOAD; serial bits for SHIFT, LSB first.
- `cmd_count` input 3: number of steps for SHIFT/ROTATE, 0..7.
- `pause` input 1: only present with `CTRL_PAUSE_EN`.
- `ch1`, `ch0` output 1 each: register mode code.
  - 00: hold.
  - 01: shift, with `d` entering q[0].
  - 10: rotate, with q[6] entering q[0].
  - 11: parallel load.
- `load_bits` output 7: parallel bits to the register.
- `d` output 1: serial bit to the register.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, EXEC, DONE.
- Handshake: accept when `cmd_valid && cmd_ready` at a rising edge. On accept, latch op, data and count; the remaining-step counter is loaded with `cmd_count`.
- IDLE:
  - Outputs: `cmd_ready`=1, mode 00, `busy`=0.
  - On accept, go to EXEC.
- EXEC with CLEAR:
  - Drive mode 11 with `load_bits`=0 for one cycle, then go to DONE.
- EXEC with LOAD:
  - Drive mode 11 with `load_bits`=latched data for one cycle, then go to DONE.
- EXEC with SHIFT:
  - Each cycle: mode 01, `d`=data[0] of the internal shift copy.
  - Each cycle the copy shifts right by one and the counter decrements.
  - When the counter reaches 0, go to DONE.
- EXEC with ROTATE:
  - Each cycle: mode 10, counter decrements.
  - When the counter reaches 0, go to DONE.
- Count 0 for SHIFT/ROTATE: EXEC lasts zero steps. Go straight to DONE with mode 00, so the register is unchanged.
- DONE:
  - Outputs: `done`=1, `busy`=1, mode 00, `cmd_ready`=0.
  - Next state is always IDLE. Back-to-back commands therefore have one IDLE cycle between them.
- Outputs outside EXEC: `ch1`/`ch0`=00, `load_bits`=0, `d`=0.
- A command presented while not ready is ignored. It is not queued; the requester holds `cmd_valid`.

## Timing
- All outputs are registered.
- Reset value of every output: `cmd_ready`=1, `busy`=0, `done`=0, `ch1`=`ch0`=0, `load_bits`=0, `d`=0. State returns to IDLE.
- The register samples mode on the edge after the controller drives it.
- Latency from accept to `done` high, for commands accepted at edge T:
  - CLEAR/LOAD: `done` high in cycle T+2.
  - SHIFT/ROTATE with count N≥1: `done` high in cycle T+1+N.
  - SHIFT/ROTATE with N=0: `done` high in cycle T+1.
- `busy` is high from T+1 through the `done` cycle inclusive.
- `rst_n` low mid-command aborts the command. The next edge forces the reset values, and no `done` is issued. The register contents are left as already stepped; the controller does not restore them.
- `rst_n` and `cmd_valid` in the same cycle: reset wins and the command is not accepted.

## Configuration
- `CTRL_PAUSE_EN` defined:
  - Adds the `pause` input.
  - In EXEC with SHIFT/ROTATE, `pause`=1 drives mode 00 and freezes the counter and shift copy.
  - A CLEAR/LOAD cycle is not paused.
  - Latency grows by the number of paused cycles.
  - `pause` is ignored in IDLE and DONE.
- `CTRL_PAUSE_EN` undefined:
  - No `pause` port.
  - EXEC never stalls.

## Test plan
- Reset, then idle: `rst_n`=0 for 2 cycles, then 1 -> `cmd_ready`=1, `busy`=0, `done`=0, mode 00, `load_bits`=0, `d`=0.
- LOAD: `cmd_op`=01, `cmd_data`=7'b1010011 accepted at T.
  - Cycle T+1: mode 11, `load_bits`=1010011.
  - Cycle T+2: `done`=1.
  - Register reads 1010011.
- SHIFT: `cmd_op`=10, `cmd_data`=7'b0000101, count 3, on a register holding 0.
  - Mode 01 for 3 cycles with `d` sequence 1,0,1.
  - `done` at T+4.
  - Register low bits hold the three bits shifted in (1,0,1) in the order defined by `contador`'s shift direction.
- ROTATE wrap: after LOAD 7'b1000000, ROTATE count 1 -> register = 0000001. ROTATE count 7 on any pattern -> register unchanged after 7 mode-10 cycles.
- Zero count and back-to-back:
  - ROTATE count 0 -> no mode-10 cycle, `done` at T+1.
  - `cmd_valid` held high with a second command -> second command accepted only in the IDLE cycle after DONE.
- Reset mid-SHIFT plus pause:
  - Deassert `rst_n` at step 2 of count 5 -> no `done`, outputs at reset values next cycle.
  - With `CTRL_PAUSE_EN`: `pause`=1 for 2 cycles during ROTATE count 3 -> `done` at T+6.

Source files
------------

// File: rtl/controle_contador.sv
`default_nettype none
// ============================================================================
// Module   : controle_contador
// Purpose  : Sequencer driving the 7-bit shift/ring register (contador):
//            CLEAR, LOAD, SHIFT-in of N bits and ROTATE by N steps.
//            Optional macro CTRL_PAUSE_EN adds a pause input that stalls
//            SHIFT/ROTATE steps.
// Revision : 1.0 - initial release
// ============================================================================
module controle_contador (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [6:0] cmd_data,
   input  logic [2:0] cmd_count,
`ifdef CTRL_PAUSE_EN
   input  logic       pause,
`endif
   output logic       ch1,
   output logic       ch0,
   output logic [6:0] load_bits,
   output logic       d,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] c_OP_CLEAR  = 2'b00;
   localparam logic [1:0] c_OP_LOAD   = 2'b01;
   localparam logic [1:0] c_OP_SHIFT  = 2'b10;
   localparam logic [1:0] c_OP_ROTATE = 2'b11;

   localparam logic [1:0] c_MODE_HOLD   = 2'b00;
   localparam logic [1:0] c_MODE_SHIFT  = 2'b01;
   localparam logic [1:0] c_MODE_ROTATE = 2'b10;
   localparam logic [1:0] c_MODE_LOAD   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_op;
   logic [6:0] r_copy;
   logic [2:0] r_count;
   logic       w_pause;

`ifdef CTRL_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   // Outputs are registered from the next-cycle decision, so the first
   // EXEC step is already on the mode pins in the cycle after the accept.
   // r_count holds the steps still to be issued after the current one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_op      <= c_OP_CLEAR;
         r_copy    <= '0;
         r_count   <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         {ch1, ch0} <= c_MODE_HOLD;
         load_bits <= '0;
         d         <= 1'b0;
      end else begin
         {ch1, ch0} <= c_MODE_HOLD;
         load_bits <= '0;
         d         <= 1'b0;
         done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               if (cmd_valid) begin
                  r_op      <= cmd_op;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_op == c_OP_CLEAR || cmd_op == c_OP_LOAD) begin
                     r_state    <= S_EXEC;
                     {ch1, ch0} <= c_MODE_LOAD;
                     load_bits  <= (cmd_op == c_OP_LOAD) ? cmd_data : 7'd0;
                  end else if (cmd_count == 3'd0) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state    <= S_EXEC;
                     {ch1, ch0} <= (cmd_op == c_OP_SHIFT) ? c_MODE_SHIFT : c_MODE_ROTATE;
                     d          <= (cmd_op == c_OP_SHIFT) ? cmd_data[0] : 1'b0;
                     r_copy     <= {1'b0, cmd_data[6:1]};
                     r_count    <= cmd_count - 3'd1;
                  end
               end
            end
            S_EXEC: begin
               if (r_op == c_OP_CLEAR || r_op == c_OP_LOAD || r_count == 3'd0) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end else if (!w_pause) begin
                  {ch1, ch0} <= (r_op == c_OP_SHIFT) ? c_MODE_SHIFT : c_MODE_ROTATE;
                  d          <= (r_op == c_OP_SHIFT) ? r_copy[0] : 1'b0;
                  r_copy     <= {1'b0, r_copy[6:1]};
                  r_count    <= r_count - 3'd1;
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
